// File: rtl/rv_mt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_mt_pkg
// Brief   : Shared hart-count, hart-id type and reset-PC constants.
// Revision: 1.0
// ============================================================================
package rv_mt_pkg;

  localparam int NUM_HARTS = 8;
  localparam int HART_W    = 3;

  typedef logic [HART_W-1:0] hart_id_t;

  localparam logic [31:0] RV_DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : rv_mt_pkg
`default_nettype wire

// File: rtl/rv_rr_pick8.sv
`default_nettype none
// ============================================================================
// Module  : rv_rr_pick8
// Brief   : Combinational round-robin picker: first set mask bit after last.
// Revision: 1.0
// ============================================================================
module rv_rr_pick8
  import rv_mt_pkg::*;
(
  input  logic [NUM_HARTS-1:0] mask,
  input  hart_id_t             last,
  output hart_id_t             sel,
  output logic                 any
);

  hart_id_t idx;

  // Offsets 1..8 from last; the 3-bit add wraps 7 -> 0, offset 8 revisits last.
  always_comb begin
    sel = last;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      idx = last + HART_W'(i);
      if (!any && mask[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule : rv_rr_pick8
`default_nettype wire

// File: rtl/rv_hart_issue.sv
`default_nettype none
// ============================================================================
// Module  : rv_hart_issue
// Brief   : 8-hart barrel issue stage with round-robin pick, block mask and
//           PC redirect bypass.
// Revision: 1.0
// ============================================================================
module rv_hart_issue
  import rv_mt_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RV_DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            hart_enable,
  input  logic                  stall,
  input  logic                  block_valid,
  input  logic [2:0]            block_hart,
  input  logic                  unblock_valid,
  input  logic [2:0]            unblock_hart,
  input  logic                  redir_valid,
  input  logic [2:0]            redir_hart,
  input  logic [DATA_WIDTH-1:0] redir_pc,
  output logic                  issue_valid,
  output logic [2:0]            issue_hart,
  output logic [DATA_WIDTH-1:0] issue_pc
);

  logic [DATA_WIDTH-1:0] pc_q [NUM_HARTS];
  logic [DATA_WIDTH-1:0] pc_d [NUM_HARTS];
  logic [NUM_HARTS-1:0]  blocked_q, blocked_d;
  hart_id_t              last_q, last_d;
  logic                  issue_valid_q, issue_valid_d;
  hart_id_t              issue_hart_q, issue_hart_d;
  logic [DATA_WIDTH-1:0] issue_pc_q, issue_pc_d;

  logic [NUM_HARTS-1:0]  eligible;
  hart_id_t              sel;
  logic                  any;
  logic [DATA_WIDTH-1:0] fetch_pc;

  assign eligible = hart_enable & ~blocked_q;

  rv_rr_pick8 u_pick (
    .mask (eligible),
    .last (last_q),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    pc_d          = pc_q;
    blocked_d     = blocked_q;
    last_d        = last_q;
    issue_valid_d = issue_valid_q;
    issue_hart_d  = issue_hart_q;
    issue_pc_d    = issue_pc_q;

    // Block applied after unblock so it wins on a same-hart collision.
    if (unblock_valid) blocked_d[unblock_hart] = 1'b0;
    if (block_valid)   blocked_d[block_hart]   = 1'b1;

    if (redir_valid) pc_d[redir_hart] = redir_pc;

    fetch_pc = (redir_valid && (redir_hart == sel)) ? redir_pc : pc_q[sel];

    if (!stall) begin
      if (any) begin
        issue_valid_d = 1'b1;
        issue_hart_d  = sel;
        issue_pc_d    = fetch_pc;
        pc_d[sel]     = fetch_pc + DATA_WIDTH'(4);
        last_d        = sel;
      end else begin
        issue_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HARTS; h++) pc_q[h] <= RESET_PC;
      blocked_q     <= '0;
      last_q        <= hart_id_t'(NUM_HARTS - 1);
      issue_valid_q <= 1'b0;
      issue_hart_q  <= '0;
      issue_pc_q    <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      blocked_q     <= blocked_d;
      last_q        <= last_d;
      issue_valid_q <= issue_valid_d;
      issue_hart_q  <= issue_hart_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_hart  = issue_hart_q;
  assign issue_pc    = issue_pc_q;

endmodule : rv_hart_issue
`default_nettype wire

// File: tb/tb_rv_hart_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_hart_issue
// Brief   : Directed + randomized bench for rv_hart_issue against a queue-free
//           behavioural model of the hart scheduler.
// Revision: 1.0
// ============================================================================
module tb_rv_hart_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  hart_enable = '0;
  logic        stall = 1'b0;
  logic        block_valid = 1'b0;
  logic [2:0]  block_hart = '0;
  logic        unblock_valid = 1'b0;
  logic [2:0]  unblock_hart = '0;
  logic        redir_valid = 1'b0;
  logic [2:0]  redir_hart = '0;
  logic [31:0] redir_pc = '0;
  logic        issue_valid;
  logic [2:0]  issue_hart;
  logic [31:0] issue_pc;

  always #5 clk = ~clk;

  rv_hart_issue #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .hart_enable   (hart_enable),
    .stall         (stall),
    .block_valid   (block_valid),
    .block_hart    (block_hart),
    .unblock_valid (unblock_valid),
    .unblock_hart  (unblock_hart),
    .redir_valid   (redir_valid),
    .redir_hart    (redir_hart),
    .redir_pc      (redir_pc),
    .issue_valid   (issue_valid),
    .issue_hart    (issue_hart),
    .issue_pc      (issue_pc)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state: what the registered outputs must show.
  logic [31:0] m_pc [8];
  logic [7:0]  m_blk;
  int          m_last;
  logic        m_valid;
  logic [2:0]  m_hart;
  logic [31:0] m_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pc[i] = 32'h0;
    m_blk   = 8'h00;
    m_last  = 7;
    m_valid = 1'b0;
    m_hart  = 3'd0;
    m_ipc   = 32'h0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    int         pick;
    int         h;
    logic [7:0] nblk;
    pick = -1;
    nblk = m_blk;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 1; k <= 8; k++) begin
        h = (m_last + k) % 8;
        if (pick < 0 && hart_enable[h] && !m_blk[h]) pick = h;
      end
      if (unblock_valid) nblk[unblock_hart] = 1'b0;
      if (block_valid)   nblk[block_hart]   = 1'b1;
      // Applying the redirect first makes a same-hart issue see the new PC.
      if (redir_valid) m_pc[redir_hart] = redir_pc;
      if (!stall) begin
        if (pick >= 0) begin
          m_valid     = 1'b1;
          m_hart      = 3'(pick);
          m_ipc       = m_pc[pick];
          m_pc[pick]  = m_pc[pick] + 32'd4;
          m_last      = pick;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_blk = nblk;
    end
  endtask

  task automatic compare_model();
    chk("model_valid", {31'b0, issue_valid}, {31'b0, m_valid});
    chk("model_hart",  {29'b0, issue_hart},  {29'b0, m_hart});
    chk("model_pc",    issue_pc,             m_ipc);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    block_valid   = 1'b0;
    unblock_valid = 1'b0;
    redir_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    compare_model();
    cycle();
    rst = 1'b0;
  endtask

  task automatic lit(input string name, input logic [2:0] h, input logic [31:0] pc);
    chk({name, "_valid"}, {31'b0, issue_valid}, 32'd1);
    chk({name, "_hart"},  {29'b0, issue_hart},  {29'b0, h});
    chk({name, "_pc"},    issue_pc,             pc);
  endtask

  initial begin
    @(negedge clk);

    // Full enable: 0..7 then 0 again with PC 4.
    do_reset();
    hart_enable = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle();
      lit("rr_full", 3'(i % 8), (i < 8) ? 32'h0 : 32'h4);
    end

    // Only harts 0 and 7 enabled: strict alternation, no bubbles.
    do_reset();
    hart_enable = 8'b1000_0001;
    cycle(); lit("alt0", 3'd0, 32'h0);
    cycle(); lit("alt1", 3'd7, 32'h0);
    cycle(); lit("alt2", 3'd0, 32'h4);
    cycle(); lit("alt3", 3'd7, 32'h4);

    // Block hart 3, then release it.
    do_reset();
    hart_enable = 8'hFF;
    cycle(); lit("blk_a", 3'd0, 32'h0);
    block_valid = 1'b1; block_hart = 3'd3;
    cycle(); lit("blk_b", 3'd1, 32'h0);
    block_valid = 1'b0;
    cycle(); lit("blk_c", 3'd2, 32'h0);
    cycle(); lit("blk_skip", 3'd4, 32'h0);
    unblock_valid = 1'b1; unblock_hart = 3'd3;
    cycle(); lit("blk_d", 3'd5, 32'h0);
    unblock_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    lit("unblk_ret", 3'd3, 32'h0);

    // Redirect bypass on the selected hart.
    do_reset();
    hart_enable = 8'hFF;
    cycle(); cycle();
    redir_valid = 1'b1; redir_hart = 3'd2; redir_pc = 32'h100;
    cycle(); lit("byp", 3'd2, 32'h100);
    redir_valid = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    lit("byp_next", 3'd2, 32'h104);

    // Stall freezes outputs; redirect during stall lands later.
    do_reset();
    hart_enable = 8'hFF;
    cycle(); cycle();
    stall = 1'b1;
    redir_valid = 1'b1; redir_hart = 3'd3; redir_pc = 32'h200;
    cycle(); lit("stall0", 3'd1, 32'h0);
    redir_valid = 1'b0;
    cycle(); lit("stall1", 3'd1, 32'h0);
    cycle(); lit("stall2", 3'd1, 32'h0);
    stall = 1'b0;
    cycle(); lit("stall_rel", 3'd2, 32'h0);
    cycle(); lit("stall_redir", 3'd3, 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    hart_enable = 8'h01;
    redir_valid = 1'b1; redir_hart = 3'd0; redir_pc = 32'hFFFF_FFFC;
    cycle(); lit("wrap0", 3'd0, 32'hFFFF_FFFC);
    redir_valid = 1'b0;
    cycle(); lit("wrap1", 3'd0, 32'h0);

    // Mid-stream reset with hart 5 blocked.
    hart_enable = 8'hFF;
    block_valid = 1'b1; block_hart = 3'd5;
    cycle();
    block_valid = 1'b0;
    redir_valid = 1'b1; redir_hart = 3'd1; redir_pc = 32'h40;
    cycle(); cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", {31'b0, issue_valid}, 32'd0);
    compare_model();
    cycle();
    rst = 1'b0;
    idle_inputs();
    cycle(); lit("rst_first", 3'd0, 32'h0);
    for (int i = 0; i < 5; i++) cycle();
    lit("rst_h5", 3'd5, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      hart_enable   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      stall         = ($urandom_range(0, 5) == 0);
      block_valid   = ($urandom_range(0, 4) == 0);
      block_hart    = 3'($urandom);
      unblock_valid = ($urandom_range(0, 2) == 0);
      unblock_hart  = 3'($urandom);
      redir_valid   = ($urandom_range(0, 4) == 0);
      redir_hart    = 3'($urandom);
      redir_pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      if (rst) model_reset();
      cycle();
    end
    rst = 1'b0;
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rv_hart_issue
`default_nettype wire

// File: doc/rv_hart_issue.md
RV_HART_ISSUE -- requirements
Module: rv_hart_issue

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 32, meaning PC and redirect-target width.
REQ-002 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning start PC of every hart.
REQ-003 The block SHALL provide: clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 The block SHALL provide: rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL provide: hart_enable  input  8  per-hart run enable.
REQ-006 The block SHALL provide: stall  input  1  downstream hold; freezes issue.
REQ-007 The block SHALL provide: block_valid  input  1  marks hart block_hart as waiting.
REQ-008 The block SHALL provide: block_hart  input  3  hart to block.
REQ-009 The block SHALL provide: unblock_valid  input  1  releases hart unblock_hart.
REQ-010 The block SHALL provide: unblock_hart  input  3  hart to release.
REQ-011 The block SHALL provide: redir_valid  input  1  PC redirect (branch/jump/trap).
REQ-012 The block SHALL provide: redir_hart  input  3  hart being redirected.
REQ-013 The block SHALL provide: redir_pc  input  DATA_WIDTH  new PC.
REQ-014 The block SHALL provide: issue_valid  output  1  registered; slot carries an instruction.
REQ-015 The block SHALL provide: issue_hart  output  3  registered hart id; drives the register file's hart_out.
REQ-016 The block SHALL provide: issue_pc  output  DATA_WIDTH  registered fetch PC of issue_hart.

Function
REQ-017 The block SHALL hold an 8-entry PC array, an 8-bit blocked mask and a 3-bit last-issued pointer.
REQ-018 eligible[h] SHALL equal hart_enable[h] AND NOT blocked[h], sampled from current-cycle state.
REQ-019 Selection SHALL be round-robin: first eligible hart searching last+1, last+2, ... mod 8; the search wraps from 7 to 0.
REQ-020 When stall=0 and an eligible hart exists, the block SHALL register issue_valid=1, issue_hart=sel, issue_pc=pc[sel] on the next edge, set last=sel and set pc[sel]=pc[sel]+4.
REQ-021 PC increment SHALL be modulo 2^DATA_WIDTH; FFFF_FFFC+4 wraps to 0.
REQ-022 When stall=0 and no hart is eligible, the block SHALL register issue_valid=0, hold issue_hart/issue_pc, and leave last unchanged.
REQ-023 When stall=1, issue_valid/issue_hart/issue_pc, last and PC increments SHALL hold; block, unblock and redirect updates still apply.
REQ-024 Redirect SHALL set pc[redir_hart]=redir_pc at the edge.
REQ-025 If redirect targets the hart selected for issue in the same unstalled cycle, the block SHALL issue redir_pc and store redir_pc+4 (redirect bypass).
REQ-026 A hart's block/unblock SHALL affect eligibility from the next cycle only; issue in the current cycle uses the old mask.
REQ-027 If block and unblock target the same hart in one cycle, block SHALL win.
REQ-028 Issue latency SHALL be exactly 1 cycle from eligible state to registered output; the block sustains one issue per unstalled cycle.

Reset
REQ-029 On rst=1 asynchronously: all pc=RESET_PC, blocked=0, last=7, issue_valid=0, issue_hart=0, issue_pc=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard pending redirects/blocks; the first issue after release is hart 0 (if eligible).

Structure
REQ-031 Shared package rv_mt_pkg SHALL define NUM_HARTS=8, HART_W=3, the hart-id type and the default RESET_PC; the register file and this block share it.
REQ-032 Round-robin selection SHALL be one combinational sub-module rv_rr_pick8 (inputs mask, last; outputs sel, any).

Verification
REQ-033 Reset then hart_enable=8'hFF, no stall -> issue_hart 0,1,...,7,0; hart 0 issues PC 0 then 4 on its second turn.
REQ-034 hart_enable=8'b1000_0001 -> issue_hart alternates 0,7,0,7 with no empty slots.
REQ-035 block_hart=3 while enabled=8'hFF -> hart 3 skipped from next cycle; unblock_hart=3 -> hart 3 issues again at its next turn with unchanged PC.
REQ-036 redir_hart=2, redir_pc=0x100 in the cycle hart 2 is selected -> issue_pc=0x100; next hart 2 issue shows 0x104.
REQ-037 stall=1 for 3 cycles -> outputs and last frozen; redirect to a hart during stall is reflected at that hart's next issue.
REQ-038 rst pulsed mid-stream with hart 5 blocked -> issue_valid=0 immediately, all PCs RESET_PC, hart 5 eligible, first issue hart 0.
